// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: synchronizes the panel bus, rebuilds BCM bit-planes into
// per-pixel colour and drains each completed row as a pixel write stream.
// Optional feature macro: HUB75_CAP_STATS_EN (row/error statistics counters).
module hub75_capture #(
    parameter int WIDTH       = 64,
    parameter int HEIGHT      = 32,
    parameter int COLOR_DEPTH = 7,
    parameter int ADDR_W      = 16
) (
    input  logic                     ctrl_clk,
    input  logic                     ctrl_rstn,
    input  logic                     hub_clk,
    input  logic                     hub_stb,
    input  logic                     hub_oe,
    input  logic                     hub_r0,
    input  logic                     hub_g0,
    input  logic                     hub_b0,
    input  logic                     hub_r1,
    input  logic                     hub_g1,
    input  logic                     hub_b1,
    input  logic                     hub_a,
    input  logic                     hub_b,
    input  logic                     hub_c,
    input  logic                     hub_d,
    input  logic                     hub_e,
    output logic                     wr_en,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [3*COLOR_DEPTH-1:0] wr_data,
    output logic                     err_len,
    output logic                     err_overrun
`ifdef HUB75_CAP_STATS_EN
    ,
    output logic [15:0]              stat_rows,
    output logic [15:0]              stat_errs
`endif
);

    localparam int HALF  = HEIGHT / 2;
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int RW    = $clog2(HALF);
    localparam int CW    = $clog2(WIDTH + 2);
    localparam int NBEAT = 2 * WIDTH;
    localparam int BW    = $clog2(NBEAT);
    localparam int PW    = $clog2(COLOR_DEPTH) + 1;
    localparam int DW    = 3 * COLOR_DEPTH;
    localparam logic [PW-1:0] PLANE_MAX  = '1;
    localparam logic [PW-1:0] LAST_PLANE = PW'(COLOR_DEPTH - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    logic [13:0]            in_s;
    logic [13:0]            sync1_r;
    logic [13:0]            sync2_r;
    logic                   clk_d_r;
    logic                   stb_d_r;
    logic                   clk_rise_s;
    logic                   stb_rise_s;
    logic [5:0]             hub_data_s;
    logic [4:0]             row_raw_s;
    logic [RW-1:0]          row_s;

    logic [CW-1:0]          col_r;
    logic [CW-1:0]          col_eff_s;
    logic [PW-1:0]          plane_r;
    logic [PW-1:0]          plane_new_s;
    logic [RW-1:0]          last_row_r;
    logic                   row_valid_r;
    logic                   len_ok_s;
    logic                   accept_s;
    logic                   err_len_s;
    logic                   new_row_s;
    logic                   complete_s;
    logic                   overrun_s;
    logic                   err_len_r;
    logic                   err_overrun_r;

    logic [5:0]             shift_r     [WIDTH];
    logic [5:0]             shift_eff_s [WIDTH];
    logic [COLOR_DEPTH-1:0] acc_r       [WIDTH][6];
    logic [COLOR_DEPTH-1:0] acc_nxt_s   [WIDTH][6];
    logic [COLOR_DEPTH-1:0] dbuf_r      [WIDTH][6];
    logic [RW-1:0]          drain_row_r;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [BW-1:0]          beat_r;
    logic [BW-1:0]          beat_nxt_s;
    logic [BW-1:0]          show_beat_s;
    logic                   wr_en_r;
    logic                   wr_en_nxt_s;
    logic                   load_s;
    logic                   fin_s;
    logic [XW-1:0]          pix_x_s;
    logic                   pix_half_s;
    logic [YW-1:0]          pix_y_s;
    logic [ADDR_W-1:0]      addr_s;
    logic [DW-1:0]          pix_s;
    logic [ADDR_W-1:0]      wr_addr_r;
    logic [DW-1:0]          wr_data_r;

    // Channel order in a shift slot: 0=r0 1=g0 2=b0 3=r1 4=g1 5=b1.
    assign in_s = {hub_clk, hub_stb, hub_oe, hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0,
                   hub_e, hub_d, hub_c, hub_b, hub_a};

    // Two-stage synchronizer plus edge-detect history for clock and strobe
    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_rstn) begin
            sync1_r <= '0;
            sync2_r <= '0;
            clk_d_r <= 1'b0;
            stb_d_r <= 1'b0;
        end else begin
            sync1_r <= in_s;
            sync2_r <= sync1_r;
            clk_d_r <= sync2_r[13];
            stb_d_r <= sync2_r[12];
        end
    end

    assign clk_rise_s = sync2_r[13] & ~clk_d_r;
    assign stb_rise_s = sync2_r[12] & ~stb_d_r;
    assign hub_data_s = sync2_r[10:5];
    assign row_raw_s  = sync2_r[4:0];
    assign row_s      = RW'(32'(row_raw_s) % HALF);

    // Data beat is folded in before the strobe so a coincident strobe sees it
    always_comb begin
        col_eff_s = col_r;
        if (clk_rise_s && (col_r != CW'(WIDTH + 1))) begin
            col_eff_s = col_r + CW'(1'b1);
        end else begin
            col_eff_s = col_r;
        end
        for (int x = 0; x < WIDTH; x++) begin
            if (clk_rise_s && (col_r == CW'(x))) begin
                shift_eff_s[x] = hub_data_s;
            end else begin
                shift_eff_s[x] = shift_r[x];
            end
        end
    end

    // Strobe evaluation: length check, plane sequencing and row completion
    always_comb begin
        len_ok_s    = (col_eff_s == CW'(WIDTH));
        accept_s    = stb_rise_s && len_ok_s;
        err_len_s   = stb_rise_s && !len_ok_s;
        new_row_s   = !row_valid_r || (row_s != last_row_r);
        plane_new_s = plane_r;
        if (new_row_s) begin
            plane_new_s = '0;
        end else if (plane_r == PLANE_MAX) begin
            plane_new_s = plane_r;
        end else begin
            plane_new_s = plane_r + PW'(1'b1);
        end
        complete_s = accept_s && (plane_new_s == LAST_PLANE);
        overrun_s  = complete_s && (state_r == DRAIN);
    end

    // Line accumulator update; plane indices past the colour depth match no bit
    always_comb begin
        for (int x = 0; x < WIDTH; x++) begin
            for (int ch = 0; ch < 6; ch++) begin
                acc_nxt_s[x][ch] = acc_r[x][ch];
                if (!accept_s) begin
                    acc_nxt_s[x][ch] = acc_r[x][ch];
                end else if (plane_new_s == '0) begin
                    acc_nxt_s[x][ch] = {{(COLOR_DEPTH-1){1'b0}}, shift_eff_s[x][ch]};
                end else begin
                    for (int p = 0; p < COLOR_DEPTH; p++) begin
                        acc_nxt_s[x][ch][p] = (PW'(p) == plane_new_s) ? shift_eff_s[x][ch]
                                                                       : acc_r[x][ch][p];
                    end
                end
            end
        end
    end

    // Capture-side state: column counter, plane tracking, shift row, accumulator, drain buffer
    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_rstn) begin
            col_r       <= '0;
            plane_r     <= '0;
            last_row_r  <= '0;
            row_valid_r <= 1'b0;
            err_len_r   <= 1'b0;
            drain_row_r <= '0;
            for (int x = 0; x < WIDTH; x++) begin
                shift_r[x] <= '0;
                for (int ch = 0; ch < 6; ch++) begin
                    acc_r[x][ch]  <= '0;
                    dbuf_r[x][ch] <= '0;
                end
            end
        end else begin
            col_r     <= stb_rise_s ? '0 : col_eff_s;
            err_len_r <= err_len_s;
            for (int x = 0; x < WIDTH; x++) begin
                shift_r[x] <= shift_eff_s[x];
                for (int ch = 0; ch < 6; ch++) begin
                    acc_r[x][ch] <= acc_nxt_s[x][ch];
                    if (complete_s) begin
                        dbuf_r[x][ch] <= acc_nxt_s[x][ch];
                    end
                end
            end
            if (accept_s) begin
                plane_r     <= plane_new_s;
                last_row_r  <= row_s;
                row_valid_r <= 1'b1;
            end
            if (complete_s) begin
                drain_row_r <= row_s;
            end
        end
    end

    // Drain FSM state register and registered write-port outputs
    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_rstn) begin
            state_r       <= IDLE;
            beat_r        <= '0;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= '0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            beat_r        <= beat_nxt_s;
            wr_en_r       <= wr_en_nxt_s;
            err_overrun_r <= overrun_s;
            if (load_s) begin
                wr_addr_r <= addr_s;
                wr_data_r <= pix_s;
            end
        end
    end

    assign fin_s = wr_en_r && wr_ready && (beat_r == BW'(NBEAT - 1));

    // Drain FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (complete_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAIN: begin
                if (overrun_s) begin
                    state_nxt_s = DRAIN;
                end else if (fin_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Drain FSM outputs: beat sequencing and the beat to present next
    always_comb begin
        beat_nxt_s  = beat_r;
        wr_en_nxt_s = wr_en_r;
        load_s      = 1'b0;
        show_beat_s = beat_r;
        case (state_r)
            IDLE: begin
                beat_nxt_s  = '0;
                wr_en_nxt_s = 1'b0;
            end
            DRAIN: begin
                if (overrun_s) begin
                    beat_nxt_s  = '0;
                    wr_en_nxt_s = 1'b0;
                end else if (!wr_en_r) begin
                    wr_en_nxt_s = 1'b1;
                    load_s      = 1'b1;
                end else if (wr_ready) begin
                    if (beat_r == BW'(NBEAT - 1)) begin
                        beat_nxt_s  = '0;
                        wr_en_nxt_s = 1'b0;
                    end else begin
                        beat_nxt_s  = beat_r + BW'(1'b1);
                        show_beat_s = beat_r + BW'(1'b1);
                        load_s      = 1'b1;
                    end
                end else begin
                    beat_nxt_s  = beat_r;
                    wr_en_nxt_s = 1'b1;
                end
            end
            default: begin
                beat_nxt_s  = '0;
                wr_en_nxt_s = 1'b0;
            end
        endcase
    end

    // Beat b covers column b/2; even beats are the top half, odd beats the bottom half
    always_comb begin
        pix_x_s    = XW'(show_beat_s >> 1);
        pix_half_s = show_beat_s[0];
        if (pix_half_s) begin
            pix_y_s = YW'(drain_row_r) + YW'(HALF);
            pix_s   = {dbuf_r[pix_x_s][5], dbuf_r[pix_x_s][4], dbuf_r[pix_x_s][3]};
        end else begin
            pix_y_s = YW'(drain_row_r);
            pix_s   = {dbuf_r[pix_x_s][2], dbuf_r[pix_x_s][1], dbuf_r[pix_x_s][0]};
        end
        addr_s = ADDR_W'({pix_y_s, pix_x_s});
    end

    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign err_len     = err_len_r;
    assign err_overrun = err_overrun_r;

`ifdef HUB75_CAP_STATS_EN
    logic [15:0] stat_rows_r;
    logic [15:0] stat_errs_r;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating counters of fully drained rows and capture errors
    always_ff @(posedge ctrl_clk) begin
        if (!ctrl_rstn) begin
            stat_rows_r <= 16'd0;
            stat_errs_r <= 16'd0;
        end else begin
            if (fin_s && !overrun_s) begin
                stat_rows_r <= sat_inc16(stat_rows_r);
            end
            if (err_len_s || overrun_s) begin
                stat_errs_r <= sat_inc16(stat_errs_r);
            end
        end
    end

    assign stat_rows = stat_rows_r;
    assign stat_errs = stat_errs_r;
`endif

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: drives HUB75 rows plane by plane and checks the
// drained pixel stream, error pulses, back-pressure and reset behaviour.
module tb_hub75_capture;

    logic        ctrl_clk = 1'b0;
    logic        ctrl_rstn;
    logic        hub_clk, hub_stb, hub_oe;
    logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic        hub_a, hub_b, hub_c, hub_d, hub_e;
    logic        wr_en, wr_ready;
    logic [15:0] wr_addr;
    logic [20:0] wr_data;
    logic        err_len, err_overrun;
`ifdef HUB75_CAP_STATS_EN
    logic [15:0] stat_rows, stat_errs;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  img [64][6];
    int          beats_seen = 0;
    logic [15:0] log_addr [2048];
    logic [20:0] log_data [2048];
    int          err_len_cnt = 0;
    int          err_ovr_cnt = 0;
    int          wr_en_cyc = 0;

    hub75_capture dut (
        .ctrl_clk(ctrl_clk), .ctrl_rstn(ctrl_rstn),
        .hub_clk(hub_clk), .hub_stb(hub_stb), .hub_oe(hub_oe),
        .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
        .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
        .hub_a(hub_a), .hub_b(hub_b), .hub_c(hub_c), .hub_d(hub_d), .hub_e(hub_e),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err_len(err_len), .err_overrun(err_overrun)
`ifdef HUB75_CAP_STATS_EN
        , .stat_rows(stat_rows), .stat_errs(stat_errs)
`endif
    );

    always #5 ctrl_clk = ~ctrl_clk;

    // Sink-side log of accepted beats and pulse counters, sampled mid-cycle
    always @(negedge ctrl_clk) begin
        if (wr_en === 1'b1) wr_en_cyc++;
        if (err_len === 1'b1) err_len_cnt++;
        if (err_overrun === 1'b1) err_ovr_cnt++;
        if (wr_en === 1'b1 && wr_ready === 1'b1 && beats_seen < 2048) begin
            log_addr[beats_seen] = wr_addr;
            log_data[beats_seen] = wr_data;
            beats_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ctrl_clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_of(input int x, input int ch, input int p);
        logic [6:0] v;
        v = img[x][ch];
        return v[p];
    endfunction

    task automatic fill_img(input int seed);
        for (int x = 0; x < 64; x++)
            for (int ch = 0; ch < 6; ch++)
                img[x][ch] = 7'((x * 5 + ch * 29 + seed * 17 + x * x) & 127);
    endtask

    task automatic send_plane(input logic [4:0] raddr, input int p, input int ncols);
        for (int x = 0; x < ncols; x++) begin
            hub_r0 = bit_of(x, 0, p); hub_g0 = bit_of(x, 1, p); hub_b0 = bit_of(x, 2, p);
            hub_r1 = bit_of(x, 3, p); hub_g1 = bit_of(x, 4, p); hub_b1 = bit_of(x, 5, p);
            cyc(2);
            hub_clk = 1'b1;
            cyc(2);
            hub_clk = 1'b0;
        end
        {hub_e, hub_d, hub_c, hub_b, hub_a} = raddr;
        cyc(2);
        hub_stb = 1'b1;
        cyc(3);
        hub_stb = 1'b0;
        cyc(3);
    endtask

    task automatic send_row(input logic [4:0] raddr);
        for (int p = 0; p < 7; p++) send_plane(raddr, p, 64);
    endtask

    task automatic wait_beats(input int base, input int n, input int budget, input string tag);
        int t;
        t = 0;
        while ((beats_seen - base) < n && t < budget) begin
            cyc(1);
            t++;
        end
        check({tag, "_reached"}, 32'((beats_seen - base) >= n), 32'd1);
    endtask

    task automatic check_drain(input int base, input int row, input string tag);
        int          mism;
        int          x, h;
        logic [15:0] ea;
        logic [20:0] ed;
        mism = 0;
        for (int k = 0; k < 128; k++) begin
            x  = k / 2;
            h  = k % 2;
            ea = 16'((row + 16 * h) * 64 + x);
            ed = {img[x][3*h+2], img[x][3*h+1], img[x][3*h]};
            if (log_addr[base+k] !== ea || log_data[base+k] !== ed) mism++;
        end
        check({tag, "_beats"}, 32'(beats_seen - base), 32'd128);
        check({tag, "_mismatch"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int base, b0, w0, cnt0, bad, en_bad;
        logic [15:0] snap_a;
        logic [20:0] snap_d;

        ctrl_rstn = 1'b0;
        hub_clk = 1'b0; hub_stb = 1'b0; hub_oe = 1'b0;
        hub_r0 = 1'b0; hub_g0 = 1'b0; hub_b0 = 1'b0;
        hub_r1 = 1'b0; hub_g1 = 1'b0; hub_b1 = 1'b0;
        {hub_e, hub_d, hub_c, hub_b, hub_a} = 5'd0;
        wr_ready = 1'b1;
        cyc(4);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_err_overrun", 32'(err_overrun), 32'd0);
        ctrl_rstn = 1'b1;
        cyc(4);

        // Row 5 with known pixel at x=3
        fill_img(1);
        img[3][0] = 7'h55; img[3][1] = 7'h00; img[3][2] = 7'h00;
        img[3][3] = 7'h00; img[3][4] = 7'h7F; img[3][5] = 7'h00;
        base = beats_seen;
        send_row(5'd5);
        wait_beats(base, 128, 400, "t1");
        cyc(20);
        check_drain(base, 5, "t1");
        check("t1_b6_addr", 32'(log_addr[base+6]), 32'd323);
        check("t1_b6_data", 32'(log_data[base+6]), 32'h55);
        check("t1_b7_addr", 32'(log_addr[base+7]), 32'd1347);
        check("t1_b7_data", 32'(log_data[base+7]), 32'h3F80);
        check("t1_idle_wr_en", 32'(wr_en), 32'd0);
        check("t1_no_err", 32'(err_len_cnt + err_ovr_cnt), 32'd0);

        // Short plane: error pulse, plane index retained
        fill_img(2);
        base = beats_seen;
        cnt0 = err_len_cnt;
        send_plane(5'd9, 0, 64);
        send_plane(5'd9, 1, 63);
        check("t2_err_len", 32'(err_len_cnt - cnt0), 32'd1);
        for (int p = 1; p < 7; p++) send_plane(5'd9, p, 64);
        wait_beats(base, 128, 400, "t2");
        cyc(20);
        check_drain(base, 9, "t2");

        // Back-pressure for 10 cycles mid-drain
        fill_img(3);
        base = beats_seen;
        send_row(5'd2);
        wait_beats(base, 20, 300, "t3_mid");
        wr_ready = 1'b0;
        cyc(1);
        snap_a = wr_addr;
        snap_d = wr_data;
        b0 = beats_seen;
        bad = 0;
        en_bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (wr_addr !== snap_a || wr_data !== snap_d) bad++;
            if (wr_en !== 1'b1) en_bad++;
        end
        check("t3_hold_stable", 32'(bad), 32'd0);
        check("t3_hold_wr_en", 32'(en_bad), 32'd0);
        check("t3_hold_no_beats", 32'(beats_seen - b0), 32'd0);
        wr_ready = 1'b1;
        wait_beats(base, 128, 300, "t3");
        cyc(20);
        check_drain(base, 2, "t3");

        // Row change after 3 planes: partial row never drains
        fill_img(4);
        base = beats_seen;
        for (int p = 0; p < 3; p++) send_plane(5'd11, p, 64);
        cyc(20);
        check("t4_no_partial_drain", 32'(beats_seen - base), 32'd0);
        fill_img(5);
        send_row(5'd12);
        wait_beats(base, 128, 400, "t4");
        cyc(20);
        check_drain(base, 12, "t4");

        // Overrun: second row completes while first is stalled; address 20 wraps to row 4
        fill_img(6);
        wr_ready = 1'b0;
        base = beats_seen;
        cnt0 = err_ovr_cnt;
        send_row(5'd20);
        cyc(5);
        check("t5_wr_en_held", 32'(wr_en), 32'd1);
        check("t5_row_mod_addr", 32'(wr_addr), 32'd256);
        fill_img(7);
        send_row(5'd7);
        cyc(2);
        check("t5_err_overrun", 32'(err_ovr_cnt - cnt0), 32'd1);
        check("t5_no_beats", 32'(beats_seen - base), 32'd0);
        wr_ready = 1'b1;
        wait_beats(base, 128, 400, "t5");
        cyc(20);
        check_drain(base, 7, "t5");

        // Reset at beat 40 of a drain
        fill_img(8);
        base = beats_seen;
        send_row(5'd1);
        wait_beats(base, 40, 300, "t6_mid");
        ctrl_rstn = 1'b0;
        cyc(1);
        check("t6_rst_wr_en", 32'(wr_en), 32'd0);
        check("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("t6_rst_wr_data", 32'(wr_data), 32'd0);
        check("t6_rst_errs", 32'(err_len | err_overrun), 32'd0);
        cyc(1);
        ctrl_rstn = 1'b1;
        b0 = beats_seen;
        w0 = wr_en_cyc;
        cyc(200);
        check("t6_no_beats_after_rst", 32'(beats_seen - b0), 32'd0);
        check("t6_no_wr_en_after_rst", 32'(wr_en_cyc - w0), 32'd0);
        fill_img(9);
        base = beats_seen;
        send_row(5'd1);
        wait_beats(base, 128, 400, "t6");
        cyc(20);
        check_drain(base, 1, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
